// File: rtl/keypad_code_fifo.sv
// Keypad press qualifier feeding a show-ahead FIFO with a sticky overflow flag.
// Optional digit accumulator on acc_value, enabled by defining KEYPAD_FIFO_ACCUM_EN.
module keypad_code_fifo #(
  parameter int DEPTH         = 8,
  parameter int AW            = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    Code,
  input  logic          Valid,
  input  logic          rd_en,
  input  logic          clr_ovf,
  output logic [3:0]    rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  output logic [15:0]   acc_value
);

  typedef enum logic [1:0] {IDLE, QUAL, HELD} state_t;

  localparam logic [7:0] STABLE_U8 = 8'(STABLE_CYCLES);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);

  state_t       state_q, state_d;
  logic [7:0]   run_q, run_d;
  logic [3:0]   code_q, code_d;
  logic         push;
  logic [3:0]   push_data;

  logic [3:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]  count_q, count_d;
  logic         ovf_q;
  logic         do_pop, do_write, drop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      run_q   <= 8'd0;
      code_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    code_d    = code_q;
    push      = 1'b0;
    push_data = code_q;
    unique case (state_q)
      IDLE: begin
        if (Valid) begin
          code_d = Code;
          run_d  = 8'd1;
          if (STABLE_U8 == 8'd1) begin
            push      = 1'b1;
            push_data = Code;
            state_d   = HELD;
          end else begin
            state_d = QUAL;
          end
        end
      end
      QUAL: begin
        if (!Valid) begin
          state_d = IDLE;
        end else if (Code != code_q) begin
          code_d = Code;
          run_d  = 8'd1;
        end else begin
          run_d = run_q + 8'd1;
          if (run_d == STABLE_U8) begin
            push    = 1'b1;
            state_d = HELD;
          end
        end
      end
      HELD: begin
        if (!Valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop frees a slot this edge, so a push into a full FIFO still lands.
  assign do_pop   = rd_en && (count_q != '0);
  assign do_write = push && ((count_q != DEPTH_C) || do_pop);
  assign drop     = push && (count_q == DEPTH_C) && !do_pop;

  always_comb begin
    count_d = count_q;
    if (do_write && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_write && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (do_write) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign rd_valid = (count_q != '0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : 4'd0;

`ifdef KEYPAD_FIFO_ACCUM_EN
  logic [15:0] acc_q;

  // Tracks every qualified press, including ones the FIFO had to drop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     acc_q <= 16'h0000;
    else if (push) acc_q <= {acc_q[11:0], push_data};
  end

  assign acc_value = acc_q;
`else
  assign acc_value = 16'h0000;
`endif

endmodule

// File: tb/tb_keypad_code_fifo.sv
// Directed bench for keypad_code_fifo: vector table plus multi-cycle corner sequences.
module tb_keypad_code_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  Code;
  logic        Valid;
  logic        rd_en;
  logic        clr_ovf;
  logic [3:0]  rd_data;
  logic        rd_valid;
  logic [3:0]  count;
  logic        full;
  logic        overflow;
  logic [15:0] acc_value;

  int errors = 0;
  int checks = 0;

  keypad_code_fifo #(.DEPTH(8), .AW(3), .STABLE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .Code(Code), .Valid(Valid), .rd_en(rd_en),
    .clr_ovf(clr_ovf), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .full(full), .overflow(overflow), .acc_value(acc_value)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       valid;
    logic [3:0] code;
    logic       rd;
    int         ecount;
    logic       erv;
    logic [3:0] edata;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input logic [3:0] c, input logic r,
                              input int ec, input logic erv, input logic [3:0] ed);
    vec_t t;
    t.valid = v; t.code = c; t.rd = r; t.ecount = ec; t.erv = erv; t.edata = ed;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One press held for 4 cycles; optional pop/clear on the qualifying cycle.
  task automatic press(input logic [3:0] c, input logic rd_last, input logic clr_last);
    Valid = 1'b1;
    Code  = c;
    for (int i = 0; i < 4; i++) begin
      rd_en   = (i == 3) ? rd_last : 1'b0;
      clr_ovf = (i == 3) ? clr_last : 1'b0;
      step();
    end
    rd_en = 1'b0; clr_ovf = 1'b0; Valid = 1'b0;
    step();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; Code = 4'd0; Valid = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    step(); step();
    chk("reset_count", int'(count), 0);
    chk("reset_rd_valid", int'(rd_valid), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_full", int'(full), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_acc", int'(acc_value), 0);
    #2 reset = 1'b0;
    step();

    // Code 7 for 4 cycles pushes on the 4th edge.
    add(1, 4'h7, 0, 0, 0, 4'h0);
    add(1, 4'h7, 0, 0, 0, 4'h0);
    add(1, 4'h7, 0, 0, 0, 4'h0);
    add(1, 4'h7, 0, 1, 1, 4'h7);
    add(0, 4'h0, 0, 1, 1, 4'h7);
    // Pop the 7 while a short press of 3 begins; 3 cycles is not enough.
    add(1, 4'h3, 1, 0, 0, 4'h0);
    add(1, 4'h3, 0, 0, 0, 4'h0);
    add(1, 4'h3, 0, 0, 0, 4'h0);
    add(0, 4'h0, 0, 0, 0, 4'h0);
    // 5,5,9,9,9,9 restarts the run on the change and pushes 9 once.
    add(1, 4'h5, 0, 0, 0, 4'h0);
    add(1, 4'h5, 0, 0, 0, 4'h0);
    add(1, 4'h9, 0, 0, 0, 4'h0);
    add(1, 4'h9, 0, 0, 0, 4'h0);
    add(1, 4'h9, 0, 0, 0, 4'h0);
    add(1, 4'h9, 0, 1, 1, 4'h9);
    for (int i = 0; i < 20; i++) add(1, 4'(i), 0, 1, 1, 4'h9);
    add(0, 4'h0, 0, 1, 1, 4'h9);
    add(0, 4'h0, 1, 0, 0, 4'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      Valid = vecs[i].valid;
      Code  = vecs[i].code;
      rd_en = vecs[i].rd;
      step();
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].ecount);
      chk($sformatf("vec%0d_rd_valid", i), int'(rd_valid), int'(vecs[i].erv));
      chk($sformatf("vec%0d_rd_data", i), int'(rd_data), int'(vecs[i].edata));
    end
    rd_en = 1'b0;
`ifdef KEYPAD_FIFO_ACCUM_EN
    chk("acc_after_table", int'(acc_value), 16'h0079);
`else
    chk("acc_after_table", int'(acc_value), 16'h0000);
`endif

    // Nine presses with no reads: the ninth is dropped.
    for (int i = 0; i < 9; i++) press(4'(i), 1'b0, 1'b0);
    chk("nine_count", int'(count), 8);
    chk("nine_full", int'(full), 1);
    chk("nine_overflow", int'(overflow), 1);
`ifdef KEYPAD_FIFO_ACCUM_EN
    chk("nine_acc", int'(acc_value), 16'h5678);
`else
    chk("nine_acc", int'(acc_value), 16'h0000);
`endif
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_data", i), int'(rd_data), i);
      pop();
    end
    chk("drained_rd_valid", int'(rd_valid), 0);
    chk("drained_rd_data", int'(rd_data), 0);
    chk("drained_count", int'(count), 0);
    pop();
    chk("pop_empty_count", int'(count), 0);
    chk("ovf_still_set", int'(overflow), 1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);

    // Full FIFO: push coincident with pop keeps count at 8 without overflow.
    for (int i = 1; i <= 8; i++) press(4'(i), 1'b0, 1'b0);
    chk("refill_full", int'(full), 1);
    press(4'hF, 1'b1, 1'b0);
    chk("pushpop_count", int'(count), 8);
    chk("pushpop_overflow", int'(overflow), 0);
    chk("pushpop_head", int'(rd_data), 2);
    // Drop and clear in the same cycle: set wins.
    press(4'hE, 1'b0, 1'b1);
    chk("set_wins_overflow", int'(overflow), 1);
    chk("set_wins_count", int'(count), 8);

    // Down to 3 entries, start a press, then reset asynchronously mid-QUAL.
    for (int i = 0; i < 5; i++) pop();
    chk("pre_reset_count", int'(count), 3);
    Valid = 1'b1; Code = 4'h2;
    step(); step();
    #2 reset = 1'b1;
    #1;
    chk("async_reset_count", int'(count), 0);
    chk("async_reset_rd_valid", int'(rd_valid), 0);
    chk("async_reset_overflow", int'(overflow), 0);
    chk("async_reset_acc", int'(acc_value), 0);
    step();
    @(negedge clock);
    reset = 1'b0;
    step(); step(); step();
    chk("fresh_press_pending", int'(count), 0);
    step();
    chk("fresh_press_count", int'(count), 1);
    chk("fresh_press_data", int'(rd_data), 2);
`ifdef KEYPAD_FIFO_ACCUM_EN
    chk("fresh_press_acc", int'(acc_value), 16'h0002);
`else
    chk("fresh_press_acc", int'(acc_value), 16'h0000);
`endif
    Valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
